// File: rtl/shift_reg_sched_pkg.sv
// ---------------------------------------------------------------------------
// shift_reg_sched_pkg
//   Shared definitions for the serial shift-register scheduler: FSM state
//   encodings and a constant-evaluable ceil(log2) helper used to size
//   counters and requester indices.
// ---------------------------------------------------------------------------
package shift_reg_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // ceil(log2(value)), never less than 1 so a vector of this width is legal
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 32'sd0;
      rem    = value - 32'sd1;
      while (rem > 32'sd0) begin
         result = result + 32'sd1;
         rem    = rem >>> 32'sd1;
      end
      return (result < 32'sd1) ? 32'sd1 : result;
   endfunction

endpackage

// File: rtl/shift_reg_sched_if.sv
// ---------------------------------------------------------------------------
// shift_reg_sched_if
//   Request/response bundle between client logic and the scheduler.
//   req_valid/req_data/req_ready : NREQ parallel word requesters, one-hot accept
//   rsp_valid/rsp_data/rsp_id/rsp_ready : collected word back to the consumer
//   master = client side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface shift_reg_sched_if
   import shift_reg_sched_pkg::*;
#(
   parameter int W    = 8,
   parameter int NREQ = 2,
   parameter int IDW  = clog2(NREQ)
) ();

   logic [NREQ-1:0]   req_valid;
   logic [NREQ*W-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic              rsp_valid;
   logic [W-1:0]      rsp_data;
   logic [IDW-1:0]    rsp_id;
   logic              rsp_ready;

   modport master (
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_id
   );

   modport slave (
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_id
   );

endinterface

// File: rtl/shift_reg_sched_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin pick: the first asserted req bit found
//   searching upward from ptr with wrap-around.
//   req       in  NREQ  request vector
//   ptr       in  IDW   highest-priority index
//   grant     out NREQ  one-hot grant (all zero when no request)
//   grant_idx out IDW   encoded grant index (0 when no request)
//   grant_any out 1     at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
   import shift_reg_sched_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IDW  = clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_idx,
   output logic            grant_any
);

   localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

   // Walk offsets from farthest to nearest so the nearest hit to ptr wins last
   always_comb begin
      int idx_s;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      idx_s     = 32'sd0;
      for (int off = NREQ - 1; off >= 0; off--) begin
         idx_s     = (int'(ptr) + off) % NREQ;
         grant     = req[idx_s] ? (ONE_HOT0 << idx_s) : grant;
         grant_idx = req[idx_s] ? IDW'(idx_s) : grant_idx;
         grant_any = grant_any | req[idx_s];
      end
   end

endmodule

// File: rtl/shift_reg_sched.sv
// ---------------------------------------------------------------------------
// shift_reg_sched
//   Shares one serial shift-register datapath among NREQ word requesters.
//   A granted word is shifted out LSB-first on sr_din (sr_en high), followed
//   by DEPTH flush zeros; the returning stream on sr_dout is collected into
//   rsp_data and presented with the owning requester id.
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   bus      slave modport of shift_reg_sched_if (request/response handshakes)
//   sr_en    out  shift enable to datapath
//   sr_din   out  serial data to datapath
//   sr_dout  in   serial data from datapath (DEPTH cycles behind sr_din)
//   busy     out  high whenever not idle
// ---------------------------------------------------------------------------
module shift_reg_sched
   import shift_reg_sched_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 3,
   parameter int NREQ  = 2,
   parameter int IDW   = clog2(NREQ)
) (
   input  logic             clk,
   input  logic             rst,
   shift_reg_sched_if.slave bus,
   output logic             sr_en,
   output logic             sr_din,
   input  logic             sr_dout,
   output logic             busy
);

   localparam int             CW       = clog2(W + DEPTH);
   localparam logic [CW-1:0]  CNT_LAST = CW'(W + DEPTH - 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
   localparam logic [IDW-1:0] ID_ONE   = IDW'(1);
   localparam logic [IDW-1:0] ID_LAST  = IDW'(NREQ - 1);

   state_t          state_r, state_n;
   logic [CW-1:0]   cnt_r, cnt_n;
   logic [W-1:0]    word_r, word_n;
   logic [IDW-1:0]  id_r, id_n;
   logic [IDW-1:0]  ptr_r, ptr_n;
   logic [W-1:0]    rsp_data_r, rsp_data_n;
   logic            sr_en_r, sr_en_n;
   logic            sr_din_r, sr_din_n;
   logic            rsp_valid_r, rsp_valid_n;
   logic            busy_r, busy_n;
   logic [NREQ-1:0] grant_s;
   logic [NREQ-1:0] req_ready_s;
   logic [IDW-1:0]  grant_idx_s;
   logic            grant_any_s;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req       (bus.req_valid),
      .ptr       (ptr_r),
      .grant     (grant_s),
      .grant_idx (grant_idx_s),
      .grant_any (grant_any_s)
   );

   // Next-state logic: accept in IDLE, count through RUN, wait for rsp_ready in RESP
   always_comb begin
      state_n     = state_r;
      cnt_n       = cnt_r;
      word_n      = word_r;
      id_n        = id_r;
      ptr_n       = ptr_r;
      req_ready_s = '0;
      case (state_r)
         ST_IDLE: begin
            // ready is suppressed during reset so no transfer appears to happen
            if (rst) begin
               req_ready_s = '0;
            end else begin
               req_ready_s = grant_s;
               if (grant_any_s) begin
                  state_n = ST_RUN;
                  cnt_n   = '0;
                  word_n  = bus.req_data[int'(grant_idx_s) * W +: W];
                  id_n    = grant_idx_s;
                  ptr_n   = (grant_idx_s == ID_LAST) ? '0 : (grant_idx_s + ID_ONE);
               end else begin
                  state_n = ST_IDLE;
               end
            end
         end
         ST_RUN: begin
            if (cnt_r == CNT_LAST) begin
               state_n = ST_RESP;
            end else begin
               cnt_n = cnt_r + CNT_ONE;
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               state_n = ST_IDLE;
            end else begin
               state_n = ST_RESP;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // Output pre-computation so every datapath/response output leaves a flop
   always_comb begin
      sr_en_n     = (state_n == ST_RUN);
      rsp_valid_n = (state_n == ST_RESP);
      busy_n      = (state_n != ST_IDLE);
      // bit cnt of the word while cnt<W, zero flush afterwards
      sr_din_n    = 1'b0;
      for (int b = 0; b < W; b++) begin
         sr_din_n = (sr_en_n && (int'(cnt_n) == b)) ? word_n[b] : sr_din_n;
      end
      // the bit driven at cnt-DEPTH is on sr_dout during cycle cnt
      rsp_data_n = rsp_data_r;
      for (int b = 0; b < W; b++) begin
         rsp_data_n[b] = ((state_r == ST_RUN) && (int'(cnt_r) == b + DEPTH)) ?
                         sr_dout : rsp_data_r[b];
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         cnt_r       <= '0;
         word_r      <= '0;
         id_r        <= '0;
         ptr_r       <= '0;
         rsp_data_r  <= '0;
         sr_en_r     <= 1'b0;
         sr_din_r    <= 1'b0;
         rsp_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_n;
         cnt_r       <= cnt_n;
         word_r      <= word_n;
         id_r        <= id_n;
         ptr_r       <= ptr_n;
         rsp_data_r  <= rsp_data_n;
         sr_en_r     <= sr_en_n;
         sr_din_r    <= sr_din_n;
         rsp_valid_r <= rsp_valid_n;
         busy_r      <= busy_n;
      end
   end

   assign sr_en         = sr_en_r;
   assign sr_din        = sr_din_r;
   assign busy          = busy_r;
   assign bus.req_ready = req_ready_s;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_data  = rsp_data_r;
   assign bus.rsp_id    = id_r;

endmodule

// File: tb/tb_shift_reg_sched.sv
// ---------------------------------------------------------------------------
// tb_shift_reg_sched
//   Drives two scheduler instances (W=8/DEPTH=3 and W=2/DEPTH=1) through
//   DEPTH-cycle delay-line datapath models and checks them against a
//   transaction-level reference: round-robin grant order, serial stream,
//   response latency, response word and id.
// ---------------------------------------------------------------------------
module tb_shift_reg_sched;

   localparam int WA = 8;
   localparam int DA = 3;
   localparam int WB = 2;
   localparam int DB = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   shift_reg_sched_if #(.W(WA), .NREQ(2), .IDW(1)) ifa ();
   shift_reg_sched_if #(.W(WB), .NREQ(2), .IDW(1)) ifb ();

   logic sr_en_a, sr_din_a, sr_dout_a, busy_a;
   logic sr_en_b, sr_din_b, sr_dout_b, busy_b;
   logic [DA-1:0] pipe_a = '0;
   logic          pipe_b = 1'b0;
   logic          inv    = 1'b0;

   int n_cmp  = 0;
   int n_bad  = 0;
   int mptr_a = 0;
   int mptr_b = 0;

   // Datapath models: DA- and DB-cycle delay lines, A optionally inverting
   always @(posedge clk) begin
      pipe_a <= {pipe_a[DA-2:0], sr_din_a};
      pipe_b <= sr_din_b;
   end
   assign sr_dout_a = pipe_a[DA-1] ^ inv;
   assign sr_dout_b = pipe_b;

   shift_reg_sched #(.W(WA), .DEPTH(DA), .NREQ(2), .IDW(1)) dut_a (
      .clk(clk), .rst(rst), .bus(ifa), .sr_en(sr_en_a), .sr_din(sr_din_a),
      .sr_dout(sr_dout_a), .busy(busy_a)
   );

   shift_reg_sched #(.W(WB), .DEPTH(DB), .NREQ(2), .IDW(1)) dut_b (
      .clk(clk), .rst(rst), .bus(ifb), .sr_en(sr_en_b), .sr_din(sr_din_b),
      .sr_dout(sr_dout_b), .busy(busy_b)
   );

   // first valid requester at or after the pointer, -1 if none
   function automatic int exp_grant(input logic [1:0] v, input int p);
      for (int off = 0; off < 2; off++) begin
         if (v[(p + off) % 2]) return (p + off) % 2;
      end
      return -1;
   endfunction

   function automatic logic [1:0] onehot(input int g);
      return (g < 0) ? 2'b00 : 2'(1 << g);
   endfunction

   // One full transaction on instance A; time is just after a negedge in IDLE
   task automatic run_txn(input logic [1:0] v, input logic [15:0] d, input bit inv_i,
                          input int rdelay, input bit keep);
      int g; int c; bit seen; logic exp_bit; logic [7:0] w; logic [7:0] expd;
      inv = inv_i;
      ifa.req_valid = v; ifa.req_data = d; ifa.rsp_ready = 1'b0;
      #1;
      g = exp_grant(v, mptr_a);
      n_cmp++;
      if (ifa.req_ready !== onehot(g)) begin
         n_bad++; $display("FAIL accept_ready: got %b want %b", ifa.req_ready, onehot(g));
      end
      if (g < 0) begin
         @(negedge clk); #1;
         n_cmp++;
         if (busy_a !== 1'b0) begin n_bad++; $display("FAIL idle_no_req busy: got %b want 0", busy_a); end
         return;
      end
      w = d[g*8 +: 8];
      expd = w ^ {8{inv_i}};
      @(posedge clk);
      mptr_a = (g + 1) % 2;
      c = 0; seen = 1'b0;
      while (!seen && c < 40) begin
         @(negedge clk);
         c++;
         if (!keep) ifa.req_valid = 2'($urandom);
         if (c <= WA + DA) ifa.rsp_ready = 1'($urandom);
         else ifa.rsp_ready = (rdelay == 0);
         #1;
         seen = (ifa.rsp_valid === 1'b1);
         if (!seen) begin
            exp_bit = (c <= WA) ? w[c-1] : 1'b0;
            n_cmp++;
            if (sr_en_a !== 1'b1 || sr_din_a !== exp_bit || busy_a !== 1'b1 || ifa.req_ready !== 2'b00) begin
               n_bad++;
               $display("FAIL run_cycle %0d: en=%b din=%b busy=%b rdy=%b want en=1 din=%b busy=1 rdy=00",
                        c, sr_en_a, sr_din_a, busy_a, ifa.req_ready, exp_bit);
            end
         end
      end
      n_cmp++;
      if (!seen || c != WA + DA + 1) begin
         n_bad++; $display("FAIL latency: got %0d cycles (seen=%b) want %0d", c, seen, WA + DA + 1);
         return;
      end
      n_cmp++;
      if (ifa.rsp_data !== expd || ifa.rsp_id !== 1'(g) || sr_en_a !== 1'b0 || sr_din_a !== 1'b0 ||
          busy_a !== 1'b1 || ifa.req_ready !== 2'b00) begin
         n_bad++;
         $display("FAIL resp: data=%h id=%b en=%b din=%b busy=%b rdy=%b want data=%h id=%0d en=0 din=0 busy=1 rdy=00",
                  ifa.rsp_data, ifa.rsp_id, sr_en_a, sr_din_a, busy_a, ifa.req_ready, expd, g);
      end
      for (int k = 0; k < rdelay; k++) begin
         @(negedge clk);
         if (!keep) ifa.req_valid = 2'($urandom);
         ifa.rsp_ready = (k == rdelay - 1);
         #1;
         n_cmp++;
         if (ifa.rsp_valid !== 1'b1 || ifa.rsp_data !== expd || ifa.rsp_id !== 1'(g) ||
             ifa.req_ready !== 2'b00 || sr_en_a !== 1'b0) begin
            n_bad++;
            $display("FAIL resp_hold %0d: valid=%b data=%h id=%b rdy=%b en=%b want 1/%h/%0d/00/0",
                     k, ifa.rsp_valid, ifa.rsp_data, ifa.rsp_id, ifa.req_ready, sr_en_a, expd, g);
         end
      end
      @(negedge clk);
      ifa.rsp_ready = 1'b0;
      if (!keep) ifa.req_valid = 2'b00;
      #1;
      n_cmp++;
      if (ifa.rsp_valid !== 1'b0 || busy_a !== 1'b0 || sr_en_a !== 1'b0 || ifa.rsp_data !== expd ||
          ifa.req_ready !== onehot(exp_grant(ifa.req_valid, mptr_a))) begin
         n_bad++;
         $display("FAIL back_to_idle: valid=%b busy=%b en=%b data=%h rdy=%b want 0/0/0/%h/%b",
                  ifa.rsp_valid, busy_a, sr_en_a, ifa.rsp_data, ifa.req_ready,
                  expd, onehot(exp_grant(ifa.req_valid, mptr_a)));
      end
   endtask

   task automatic test_reset();
      ifa.req_valid = 2'b11; ifa.req_data = 16'h2211; ifa.rsp_ready = 1'b1;
      ifb.req_valid = 2'b00; ifb.req_data = 4'h0;     ifb.rsp_ready = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      n_cmp++;
      if (ifa.req_ready !== 2'b00 || sr_en_a !== 1'b0 || sr_din_a !== 1'b0 || ifa.rsp_valid !== 1'b0 ||
          ifa.rsp_data !== 8'h00 || ifa.rsp_id !== 1'b0 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_state: rdy=%b en=%b din=%b valid=%b data=%h id=%b busy=%b/%b want all 0",
                  ifa.req_ready, sr_en_a, sr_din_a, ifa.rsp_valid, ifa.rsp_data, ifa.rsp_id, busy_a, busy_b);
      end
      ifa.req_valid = 2'b00; ifa.rsp_ready = 1'b0;
      rst = 1'b0;
      mptr_a = 0; mptr_b = 0;
   endtask

   task automatic test_basic();
      run_txn(2'b01, 16'h00A5, 1'b0, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int t = 0; t < 4; t++) run_txn(2'b11, 16'h2211, 1'b0, 0, 1'b1);
      ifa.req_valid = 2'b00;
   endtask

   task automatic test_resp_stall();
      run_txn(2'b01, 16'($urandom), 1'b0, 5, 1'b0);
   endtask

   task automatic test_reset_mid_run();
      inv = 1'b0;
      ifa.req_valid = 2'b01; ifa.req_data = 16'($urandom); ifa.rsp_ready = 1'b0;
      @(posedge clk);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         ifa.req_valid = 2'b00;
      end
      #1;
      n_cmp++;
      if (sr_en_a !== 1'b1) begin n_bad++; $display("FAIL mid_run_en: got %b want 1", sr_en_a); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mptr_a = 0; mptr_b = 0;
      #1;
      n_cmp++;
      if (sr_en_a !== 1'b0 || busy_a !== 1'b0 || ifa.rsp_valid !== 1'b0 || ifa.rsp_data !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_mid_run: en=%b busy=%b valid=%b data=%h want 0/0/0/00",
                  sr_en_a, busy_a, ifa.rsp_valid, ifa.rsp_data);
      end
      for (int k = 0; k < 15; k++) begin
         @(negedge clk); #1;
         n_cmp++;
         if (ifa.rsp_valid !== 1'b0 || busy_a !== 1'b0) begin
            n_bad++; $display("FAIL no_rsp_after_reset %0d: valid=%b busy=%b want 0/0", k, ifa.rsp_valid, busy_a);
         end
      end
      run_txn(2'b11, 16'($urandom), 1'b0, 0, 1'b0);
      run_txn(2'b10, 16'($urandom), 1'b0, 1, 1'b0);
   endtask

   task automatic test_invert();
      run_txn(2'b10, 16'h3C00, 1'b1, 0, 1'b0);
      inv = 1'b0;
   endtask

   task automatic test_lost_request();
      run_txn(2'b01, 16'($urandom), 1'b0, 2, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         n_cmp++;
         if (busy_a !== 1'b0 || ifa.req_ready !== 2'b00) begin
            n_bad++; $display("FAIL lost_request %0d: busy=%b rdy=%b want 0/00", k, busy_a, ifa.req_ready);
         end
      end
   endtask

   task automatic test_random();
      for (int t = 0; t < 20; t++) begin
         run_txn(2'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
      end
      ifa.req_valid = 2'b00;
      inv = 1'b0;
   endtask

   task automatic test_small();
      for (int t = 0; t < 4; t++) begin
         logic [1:0] v; logic [3:0] d; logic [1:0] w; int g; int c; bit seen;
         v = 2'($urandom_range(1, 3)); d = 4'($urandom);
         ifb.req_valid = v; ifb.req_data = d; ifb.rsp_ready = 1'b1;
         #1;
         g = exp_grant(v, mptr_b);
         n_cmp++;
         if (ifb.req_ready !== onehot(g)) begin
            n_bad++; $display("FAIL small_ready: got %b want %b", ifb.req_ready, onehot(g));
         end
         @(posedge clk);
         mptr_b = (g + 1) % 2;
         w = d[g*2 +: 2];
         c = 0; seen = 1'b0;
         while (!seen && c < 20) begin
            @(negedge clk);
            ifb.req_valid = 2'b00;
            #1;
            c++;
            seen = (ifb.rsp_valid === 1'b1);
         end
         n_cmp++;
         if (!seen || c != WB + DB + 1 || ifb.rsp_data !== w || ifb.rsp_id !== 1'(g) || sr_en_b !== 1'b0) begin
            n_bad++;
            $display("FAIL small_resp: cycles=%0d seen=%b data=%b id=%b en=%b want %0d/1/%b/%0d/0",
                     c, seen, ifb.rsp_data, ifb.rsp_id, sr_en_b, WB + DB + 1, w, g);
         end
         @(negedge clk); #1;
         n_cmp++;
         if (ifb.rsp_valid !== 1'b0 || busy_b !== 1'b0) begin
            n_bad++; $display("FAIL small_idle: valid=%b busy=%b want 0/0", ifb.rsp_valid, busy_b);
         end
      end
      ifb.rsp_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_resp_stall();
      test_reset_mid_run();
      test_invert();
      test_lost_request();
      test_small();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
